// File: rtl/regfile_sb.sv
// Register file with scoreboard busy bits: one write port, one reserve port and two
// read ports that stall on pending registers. All state updates on the falling clock edge.
module regfile_sb #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic             rsv_err,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid_a,
  output logic             rd_valid_b,
  output logic             rd_wait_a,
  output logic             rd_wait_b,
  output logic [DEPTH-1:0] busy
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  function automatic logic in_range(input logic [AW-1:0] a);
    return (int'(a) < DEPTH);
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             rsv_err_q, rsv_err_d;
  logic             wr_hit, rsv_hit, rsv_ok;

  logic [1:0]       rd_en_v;
  logic [AW-1:0]    rd_addr_v [2];
  logic [WIDTH-1:0] rd_data_v [2];
  logic [1:0]       rd_valid_v, rd_wait_v;

  assign rd_en_v      = {rd_en_b, rd_en_a};
  assign rd_addr_v[0] = rd_addr_a;
  assign rd_addr_v[1] = rd_addr_b;

  // A reserve is refused only when the register is already pending and not being written now.
  always_comb begin
    wr_hit    = wr_en && in_range(wr_addr);
    rsv_hit   = rsv_en && in_range(rsv_addr);
    rsv_ok    = rsv_hit && (!busy_q[rsv_addr] || (wr_hit && (wr_addr == rsv_addr)));
    rsv_err_d = rsv_hit && !rsv_ok;
    busy_d    = busy_q;
    if (wr_hit) begin
      busy_d[wr_addr] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q    <= '0;
      rsv_err_q <= 1'b0;
    end else begin
      if (wr_hit) begin
        mem_q[wr_addr] <= wr_data;
      end
      busy_q    <= busy_d;
      rsv_err_q <= rsv_err_d;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // Same-edge write wins over busy and over stored data; busy is the pre-edge view.
    always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      valid_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rd_en_v[p]) begin
            state_d = S_IDLE;
          end else if (!in_range(rd_addr_v[p])) begin
            data_d  = '0;
            valid_d = 1'b1;
          end else if (wr_hit && (wr_addr == rd_addr_v[p])) begin
            data_d  = wr_data;
            valid_d = 1'b1;
          end else if (busy_q[rd_addr_v[p]]) begin
            addr_d  = rd_addr_v[p];
            state_d = S_WAIT;
          end else begin
            data_d  = mem_q[rd_addr_v[p]];
            valid_d = 1'b1;
          end
        end
        S_WAIT: begin
          if (wr_hit && (wr_addr == addr_q)) begin
            data_d  = wr_data;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    always_ff @(negedge clk) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        addr_q  <= '0;
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        state_q <= state_d;
        addr_q  <= addr_d;
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    assign rd_data_v[p]  = data_q;
    assign rd_valid_v[p] = valid_q;
    assign rd_wait_v[p]  = (state_q == S_WAIT);
  end

  assign rd_data_a  = rd_data_v[0];
  assign rd_data_b  = rd_data_v[1];
  assign rd_valid_a = rd_valid_v[0];
  assign rd_valid_b = rd_valid_v[1];
  assign rd_wait_a  = rd_wait_v[0];
  assign rd_wait_b  = rd_wait_v[1];
  assign rsv_err    = rsv_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: expected read data is queued at issue time and a
// monitor thread pops it whenever a read port pulses rd_valid.
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0, rsv_en = 1'b0, rd_en_a = 1'b0, rd_en_b = 1'b0;
  logic [3:0]  wr_addr = '0, rsv_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
  logic [15:0] wr_data = '0;

  logic        rsv_err, rd_valid_a, rd_valid_b, rd_wait_a, rd_wait_b;
  logic [15:0] rd_data_a, rd_data_b, busy;
  logic        rsv_err12, rd_valid_a12, rd_valid_b12, rd_wait_a12, rd_wait_b12;
  logic [15:0] rd_data_a12, rd_data_b12;
  logic [11:0] busy12;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(16), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_err(rsv_err),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid_a(rd_valid_a),
    .rd_valid_b(rd_valid_b), .rd_wait_a(rd_wait_a), .rd_wait_b(rd_wait_b), .busy(busy));

  regfile_sb #(.WIDTH(16), .DEPTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_err(rsv_err12),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a12), .rd_data_b(rd_data_b12), .rd_valid_a(rd_valid_a12),
    .rd_valid_b(rd_valid_b12), .rd_wait_a(rd_wait_a12), .rd_wait_b(rd_wait_b12), .busy(busy12));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    wr_en = 1'b0; rsv_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
  endtask

  // One falling (active) edge, then settle past the following rising edge.
  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #2;
    clr();
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic rsv(input logic [3:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  task automatic rda(input logic [3:0] a);
    rd_en_a = 1'b1; rd_addr_a = a;
  endtask

  task automatic rdb(input logic [3:0] a);
    rd_en_b = 1'b1; rd_addr_b = a;
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk);
        if (rd_valid_a) begin
          if (qa.size() == 0) chk("rd_a_unexpected_valid", 32'(rd_data_a), 32'hDEAD_0000);
          else chk("rd_data_a", 32'(rd_data_a), 32'(qa.pop_front()));
        end
        if (rd_valid_b) begin
          if (qb.size() == 0) chk("rd_b_unexpected_valid", 32'(rd_data_b), 32'hDEAD_0000);
          else chk("rd_data_b", 32'(rd_data_b), 32'(qb.pop_front()));
        end
      end
    join_none

    // Reset state
    step(); step();
    chk("rst_rd_data_a", 32'(rd_data_a), 32'h0);
    chk("rst_rd_valid_a", 32'(rd_valid_a), 32'h0);
    chk("rst_rd_wait_b", 32'(rd_wait_b), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsv_err", 32'(rsv_err), 32'h0);
    rst_n = 1'b1;

    // Plain write then read with one-edge latency; data holds afterwards
    wr(4'd3, 16'hBEEF); step();
    rda(4'd3); qa.push_back(16'hBEEF); step();
    chk("beef_served", 32'(qa.size()), 32'h0);
    step();
    chk("hold_valid_a", 32'(rd_valid_a), 32'h0);
    chk("hold_data_a", 32'(rd_data_a), 32'hBEEF);

    // Port B waits on reserved r5; a request during WAIT is dropped
    rsv(4'd5); step();
    chk("busy5_set", 32'(busy[5]), 32'h1);
    rdb(4'd5); step();
    chk("wait_b", 32'(rd_wait_b), 32'h1);
    chk("wait_b_novalid", 32'(rd_valid_b), 32'h0);
    rdb(4'd3); step();
    step();
    wr(4'd5, 16'h1234); qb.push_back(16'h1234); step();
    chk("wake_b_served", 32'(qb.size()), 32'h0);
    chk("wake_wait_b", 32'(rd_wait_b), 32'h0);
    chk("wake_busy5", 32'(busy[5]), 32'h0);

    // Double reserve
    rsv(4'd2); step();
    chk("rsv1_err", 32'(rsv_err), 32'h0);
    rsv(4'd2); step();
    chk("rsv2_err", 32'(rsv_err), 32'h1);
    chk("rsv2_busy2", 32'(busy[2]), 32'h1);
    step();
    chk("rsv_err_pulse", 32'(rsv_err), 32'h0);

    // Write-first on both ports
    wr(4'd7, 16'h0001); step();
    wr(4'd7, 16'h00FF); rda(4'd7); rdb(4'd7);
    qa.push_back(16'h00FF); qb.push_back(16'h00FF); step();
    chk("r7_both_served", 32'(qa.size() + qb.size()), 32'h0);

    // Write + reserve same busy register: no error, stays busy
    wr(4'd2, 16'h2222); rsv(4'd2); step();
    chk("wr_rsv_err", 32'(rsv_err), 32'h0);
    chk("wr_rsv_busy2", 32'(busy[2]), 32'h1);
    // Bypass read of busy register written on same edge
    wr(4'd2, 16'h3333); rda(4'd2); qa.push_back(16'h3333); step();
    chk("bypass_wait_a", 32'(rd_wait_a), 32'h0);
    chk("bypass_busy2", 32'(busy[2]), 32'h0);
    // Read of register reserved on the same edge returns stored value
    rsv(4'd4); rda(4'd4); qa.push_back(16'h0000); step();
    chk("rsvread_busy4", 32'(busy[4]), 32'h1);
    chk("rsvread_wait_a", 32'(rd_wait_a), 32'h0);
    chk("rsvread_served", 32'(qa.size()), 32'h0);

    // Reset discards a pending WAIT
    rsv(4'd9); step();
    rda(4'd9); step();
    chk("r9_wait_a", 32'(rd_wait_a), 32'h1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("rst2_wait_a", 32'(rd_wait_a), 32'h0);
    chk("rst2_busy", 32'(busy), 32'h0);
    chk("rst2_data_a", 32'(rd_data_a), 32'h0);
    wr(4'd9, 16'h5555); step();
    step();
    rda(4'd9); qa.push_back(16'h5555); step();
    rda(4'd3); qa.push_back(16'h0000); step();
    chk("post_rst_served", 32'(qa.size()), 32'h0);

    // Out-of-range on DEPTH=12 (r13 is legal on DEPTH=16)
    wr(4'd13, 16'hABCD); step();
    rda(4'd13); rdb(4'd9); qa.push_back(16'hABCD); qb.push_back(16'h5555); step();
    chk("oor12_valid_a", 32'(rd_valid_a12), 32'h1);
    chk("oor12_data_a", 32'(rd_data_a12), 32'h0);
    chk("oor12_r9_kept", 32'(rd_data_b12), 32'h5555);
    rsv(4'd13); step();
    chk("oor12_rsv_err", 32'(rsv_err12), 32'h0);
    chk("oor12_busy", 32'(busy12), 32'h0);
    chk("r13_busy16", 32'(busy[13]), 32'h1);
    chk("final_queues", 32'(qa.size() + qb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 16, number of registers; AW = ceil(log2(DEPTH)), minimum 1.
REQ-003 clk  input  1  single clock; all state updates on the falling edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 wr_en  input  1  write strobe.
REQ-006 wr_addr  input  AW  write register index.
REQ-007 wr_data  input  WIDTH  write data.
REQ-008 rsv_en  input  1  reserve strobe; marks a register pending.
REQ-009 rsv_addr  input  AW  reserve register index.
REQ-010 rsv_err  output  1  one-cycle pulse: reserve refused.
REQ-011 rd_en_a, rd_en_b  input  1 each  read request, ports A and B.
REQ-012 rd_addr_a, rd_addr_b  input  AW each  read register index.
REQ-013 rd_data_a, rd_data_b  output  WIDTH each  registered read data.
REQ-014 rd_valid_a, rd_valid_b  output  1 each  one-cycle pulse: rd_data is new.
REQ-015 rd_wait_a, rd_wait_b  output  1 each  port is blocked on a pending register.
REQ-016 busy  output  DEPTH  pending-bit vector; bit i is register i.

Function
REQ-017 Storage is DEPTH x WIDTH; one write port and two independent read ports per falling edge.
REQ-018 Write: wr_en=1 with wr_addr<DEPTH stores wr_data and clears busy[wr_addr].
REQ-019 Reserve: rsv_en=1 with busy[rsv_addr]=0 sets busy[rsv_addr].
REQ-020 Reserve of an already-busy register that is not written on the same edge: busy unchanged, rsv_err=1 for one cycle.
REQ-021 Write and reserve to the same address on the same edge: data stored, busy left set, rsv_err=0.
REQ-022 Each read port is a 2-state FSM: IDLE, WAIT.
REQ-023 IDLE, rd_en=1, target not busy: rd_data loads the register value, rd_valid=1 next cycle (latency 1 edge).
REQ-024 IDLE, rd_en=1, target busy and written on the same edge: rd_data loads wr_data (bypass), rd_valid=1, stay IDLE.
REQ-025 IDLE, rd_en=1, target busy and not written: latch the address, go to WAIT, rd_wait=1, rd_valid=0.
REQ-026 WAIT: on the edge where wr_en hits the latched address, rd_data=wr_data, rd_valid=1, rd_wait=0, go to IDLE.
REQ-027 WAIT: rd_en is ignored; no request is queued.
REQ-028 Read of a non-busy register being written on the same edge returns wr_data (write-first).
REQ-029 Read of a register being reserved on the same edge, but not busy before the edge, returns the stored value and does not wait.
REQ-030 Ports A and B may target the same address on the same edge; both are served identically.
REQ-031 rd_data holds its last value while rd_valid=0; it never drives z.
REQ-032 Address >= DEPTH: writes and reserves are ignored; reads return 0 with rd_valid=1; rsv_err=0.
REQ-033 busy reflects state after the most recent falling edge.

Reset
REQ-034 rst_n=0 sampled on a falling edge clears all registers to 0 and busy to 0.
REQ-035 Reset forces both ports to IDLE and sets rd_data_*=0, rd_valid_*=0, rd_wait_*=0, rsv_err=0.
REQ-036 Reset overrides every request on the same edge, including a read pending in WAIT, which is discarded.
REQ-037 After reset deasserts, the first falling edge with a request is served normally.

Verification
REQ-038 Reset, write 0xBEEF to r3, read r3 on A -> next cycle rd_data_a=0xBEEF, rd_valid_a=1 for one cycle.
REQ-039 Reserve r5, read r5 on B -> rd_wait_b=1; three edges later write 0x1234 to r5 -> same edge rd_data_b=0x1234, rd_valid_b=1, rd_wait_b=0, busy[5]=0.
REQ-040 Reserve r2 twice on consecutive edges -> second reserve gives rsv_err=1 for one cycle, busy[2]=1.
REQ-041 r7=0x0001 not busy; write 0x00FF to r7 and read r7 on A and B on the same edge -> both return 0x00FF.
REQ-042 Port A in WAIT on r9; assert rst_n=0 for one edge -> rd_wait_a=0, busy=0, r9=0; a later write to r9 produces no rd_valid_a.
REQ-043 DEPTH=12: write to r13, then read r13 -> rd_data=0, rd_valid=1; r0..r11 unchanged.
